// File: rtl/pmem_arb_pkg.sv
// pmem_arb shared types: arbiter state, read-data owner tag,
// default memory geometry and starve counter width.
package pmem_arb_pkg;

  localparam int PMEM_DEPTH = 32768;
  localparam int PMEM_AW    = 15;
  localparam int STARVE_W   = 4;

  typedef enum logic {
    RUN  = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_LD    = 2'd2
  } owner_e;

endpackage

// File: rtl/pmem_arb.sv
// pmem_arb: single-port program memory arbiter, fetch vs loader.
// Fetch has priority; a starve counter forces a loader grant, and
// the loader can lock the port. _c0 ports: requests/grants and the
// memory command; _c1 ports: read data/valid/err one cycle later.
// Clock clk, synchronous active-low rst_n.
// Optional macro PMEM_ARB_STATS_EN adds output conflict_cnt[15:0].
module pmem_arb
  import pmem_arb_pkg::*;
#(
  parameter int DEPTH      = PMEM_DEPTH,
  parameter int AW         = PMEM_AW,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fetch_req_c0,
  input  logic [31:0]   fetch_addr_c0,
  output logic          fetch_gnt_c0,
  output logic          fetch_vld_c1,
  output logic [31:0]   fetch_instr_c1,
  input  logic          ld_req_c0,
  input  logic          ld_we_c0,
  input  logic          ld_lock_c0,
  input  logic [31:0]   ld_addr_c0,
  input  logic [31:0]   ld_wdata_c0,
  output logic          ld_gnt_c0,
  output logic          ld_vld_c1,
  output logic [31:0]   ld_rdata_c1,
  output logic          ld_err_c1,
  output logic          locked,
  output logic          mem_en_c0,
  output logic          mem_we_c0,
  output logic [AW-1:0] mem_addr_c0,
  output logic [31:0]   mem_wdata_c0,
  input  logic [31:0]   mem_rdata_c1
`ifdef PMEM_ARB_STATS_EN
  ,
  output logic [15:0]   conflict_cnt
`endif
);

  localparam logic [STARVE_W-1:0] STARVE_LIM =
    STARVE_W'(STARVE_MAX);
  localparam logic [32:0] LD_LIMIT = 33'(DEPTH) << 2;

  arb_state_e          state_q, state_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  owner_e              owner_q, owner_d;
  logic                err_q, err_d;
  logic [31:0]         instr_q, instr_d;
  logic [31:0]         rdata_q, rdata_d;

  logic ld_in_range;
  logic conflict;

  // fetch high bits are dropped on purpose: fetch wraps
  logic unused_bits;
  assign unused_bits = ^{fetch_addr_c0[31:AW+2],
                         fetch_addr_c0[1:0]};

  assign ld_in_range = {1'b0, ld_addr_c0} < LD_LIMIT;

  always_comb begin
    fetch_gnt_c0 = 1'b0;
    ld_gnt_c0    = 1'b0;
    conflict     = 1'b0;
    state_d      = state_q;
    starve_d     = starve_q;
    if (rst_n) begin
      unique case (state_q)
        RUN: begin
          if (fetch_req_c0 && ld_req_c0) begin
            conflict = 1'b1;
            if (starve_q == STARVE_LIM) ld_gnt_c0 = 1'b1;
            else fetch_gnt_c0 = 1'b1;
          end else if (fetch_req_c0) begin
            fetch_gnt_c0 = 1'b1;
          end else if (ld_req_c0) begin
            ld_gnt_c0 = 1'b1;
          end
          if (ld_gnt_c0 && ld_lock_c0) state_d = LOCK;
        end
        LOCK: begin
          // loader cannot lose arbitration here, even on
          // the cycle that releases the lock
          ld_gnt_c0 = ld_req_c0;
          if (!ld_lock_c0) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
      if (!ld_req_c0 || ld_gnt_c0) starve_d = '0;
      else if (conflict) starve_d = starve_q + 1'b1;
    end
  end

  always_comb begin
    mem_en_c0    = fetch_gnt_c0 | (ld_gnt_c0 & ld_in_range);
    mem_we_c0    = ld_gnt_c0 & ld_we_c0 & ld_in_range;
    mem_addr_c0  = '0;
    mem_wdata_c0 = '0;
    unique case (1'b1)
      fetch_gnt_c0: mem_addr_c0 = fetch_addr_c0[AW+1:2];
      ld_gnt_c0:    mem_addr_c0 = ld_addr_c0[AW+1:2];
      default:      mem_addr_c0 = '0;
    endcase
    if (mem_we_c0) mem_wdata_c0 = ld_wdata_c0;
  end

  // owner tag steers next-cycle read data; writes and
  // out-of-range loader accesses own nothing
  always_comb begin
    owner_d = OWN_NONE;
    err_d   = ld_gnt_c0 & ~ld_in_range;
    unique case (1'b1)
      fetch_gnt_c0: owner_d = OWN_FETCH;
      ld_gnt_c0: begin
        if (ld_in_range && !ld_we_c0) owner_d = OWN_LD;
      end
      default: owner_d = OWN_NONE;
    endcase
  end

  always_comb begin
    instr_d = instr_q;
    rdata_d = rdata_q;
    if (owner_q == OWN_FETCH) instr_d = mem_rdata_c1;
    if (owner_q == OWN_LD)    rdata_d = mem_rdata_c1;
  end

  assign fetch_vld_c1   = (owner_q == OWN_FETCH);
  assign ld_vld_c1      = (owner_q == OWN_LD);
  assign fetch_instr_c1 = instr_d;
  assign ld_rdata_c1    = rdata_d;
  assign ld_err_c1      = err_q;
  assign locked         = (state_q == LOCK);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= RUN;
      starve_q <= '0;
      owner_q  <= OWN_NONE;
      err_q    <= 1'b0;
      instr_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      owner_q  <= owner_d;
      err_q    <= err_d;
      instr_q  <= instr_d;
      rdata_q  <= rdata_d;
    end
  end

`ifdef PMEM_ARB_STATS_EN
  logic [15:0] conflict_q, conflict_d;

  always_comb begin
    conflict_d = conflict_q;
    if (conflict && conflict_q != 16'hFFFF)
      conflict_d = conflict_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) conflict_q <= '0;
    else        conflict_q <= conflict_d;
  end

  assign conflict_cnt = conflict_q;
`endif

endmodule

// File: tb/tb_pmem_arb.sv
// tb_pmem_arb: directed bench for pmem_arb with a small
// registered-read memory model on the mem_* port.
module tb_pmem_arb;

  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fetch_req_c0;
  logic [31:0]   fetch_addr_c0;
  logic          fetch_gnt_c0;
  logic          fetch_vld_c1;
  logic [31:0]   fetch_instr_c1;
  logic          ld_req_c0;
  logic          ld_we_c0;
  logic          ld_lock_c0;
  logic [31:0]   ld_addr_c0;
  logic [31:0]   ld_wdata_c0;
  logic          ld_gnt_c0;
  logic          ld_vld_c1;
  logic [31:0]   ld_rdata_c1;
  logic          ld_err_c1;
  logic          locked;
  logic          mem_en_c0;
  logic          mem_we_c0;
  logic [AW-1:0] mem_addr_c0;
  logic [31:0]   mem_wdata_c0;
  logic [31:0]   mem_rdata_c1 = 32'h0;
`ifdef PMEM_ARB_STATS_EN
  logic [15:0]   conflict_cnt;
`endif

  int errors = 0;
  int checks = 0;

  pmem_arb #(
    .DEPTH(32768), .AW(AW), .STARVE_MAX(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req_c0(fetch_req_c0),
    .fetch_addr_c0(fetch_addr_c0),
    .fetch_gnt_c0(fetch_gnt_c0),
    .fetch_vld_c1(fetch_vld_c1),
    .fetch_instr_c1(fetch_instr_c1),
    .ld_req_c0(ld_req_c0), .ld_we_c0(ld_we_c0),
    .ld_lock_c0(ld_lock_c0), .ld_addr_c0(ld_addr_c0),
    .ld_wdata_c0(ld_wdata_c0), .ld_gnt_c0(ld_gnt_c0),
    .ld_vld_c1(ld_vld_c1), .ld_rdata_c1(ld_rdata_c1),
    .ld_err_c1(ld_err_c1), .locked(locked),
    .mem_en_c0(mem_en_c0), .mem_we_c0(mem_we_c0),
    .mem_addr_c0(mem_addr_c0),
    .mem_wdata_c0(mem_wdata_c0),
    .mem_rdata_c1(mem_rdata_c1)
`ifdef PMEM_ARB_STATS_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:255];
  logic        mem_init = 1'b0;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[0]    <= 32'h11;
      mem[1]    <= 32'h22;
      mem[2]    <= 32'h33;
      mem[8'h40] <= 32'hCAFE0100;
      mem_init  <= 1'b1;
    end else if (mem_en_c0) begin
      if (mem_we_c0) mem[mem_addr_c0[7:0]] <= mem_wdata_c0;
      mem_rdata_c1 <= mem[mem_addr_c0[7:0]];
    end
  end

  task automatic idle();
    fetch_req_c0  = 1'b0;
    fetch_addr_c0 = 32'h0;
    ld_req_c0     = 1'b0;
    ld_we_c0      = 1'b0;
    ld_lock_c0    = 1'b0;
    ld_addr_c0    = 32'h0;
    ld_wdata_c0   = 32'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({fetch_gnt_c0, ld_gnt_c0, fetch_vld_c1, ld_vld_c1,
         ld_err_c1, locked, mem_en_c0, mem_we_c0} !== 8'h0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0",
        {fetch_gnt_c0, ld_gnt_c0, fetch_vld_c1, ld_vld_c1,
         ld_err_c1, locked, mem_en_c0, mem_we_c0});
    end
    checks++;
    if ({fetch_instr_c1, ld_rdata_c1} !== 64'h0) begin
      errors++;
      $display("FAIL reset_data: got %h %h want 0",
        fetch_instr_c1, ld_rdata_c1);
    end
    // fetch granted, then reset asserted mid-stream
    @(negedge clk);
    rst_n = 1'b1;
    fetch_req_c0 = 1'b1;
    fetch_addr_c0 = 32'h0;
    #1;
    checks++;
    if (fetch_gnt_c0 !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_gnt: got %b want 1", fetch_gnt_c0);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({fetch_gnt_c0, mem_en_c0} !== 2'b00) begin
      errors++;
      $display("FAIL rst_gnt_low: got %b want 00",
        {fetch_gnt_c0, mem_en_c0});
    end
    checks++;
    if (fetch_vld_c1 !== 1'b1 || fetch_instr_c1 !== 32'h11) begin
      errors++;
      $display("FAIL rst_pre_data: got %b %h want 1 00000011",
        fetch_vld_c1, fetch_instr_c1);
    end
    @(negedge clk);
    #1;
    checks++;
    if (fetch_vld_c1 !== 1'b0 || fetch_instr_c1 !== 32'h0) begin
      errors++;
      $display("FAIL rst_discard: got %b %h want 0 0",
        fetch_vld_c1, fetch_instr_c1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle();
  endtask

  task automatic test_fetch_b2b();
    logic [31:0] addr [4] = '{32'h0, 32'h4, 32'h8, 32'h0};
    logic [31:0] exp  [4] = '{32'h0, 32'h11, 32'h22, 32'h33};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      fetch_req_c0  = (i < 3);
      fetch_addr_c0 = (i < 4) ? addr[i] : 32'h0;
      #1;
      if (i < 3) begin
        checks++;
        if (fetch_gnt_c0 !== 1'b1 || mem_en_c0 !== 1'b1 ||
            mem_addr_c0 !== AW'(i)) begin
          errors++;
          $display("FAIL fetch_gnt[%0d]: got %b %b %h want 1 1 %h",
            i, fetch_gnt_c0, mem_en_c0, mem_addr_c0, i);
        end
      end
      if (i >= 1 && i <= 3) begin
        checks++;
        if (fetch_vld_c1 !== 1'b1 || fetch_instr_c1 !== exp[i]) begin
          errors++;
          $display("FAIL fetch_data[%0d]: got %b %h want 1 %h",
            i, fetch_vld_c1, fetch_instr_c1, exp[i]);
        end
      end
      if (i == 4) begin
        checks++;
        if (fetch_vld_c1 !== 1'b0 || fetch_instr_c1 !== 32'h33) begin
          errors++;
          $display("FAIL fetch_hold: got %b %h want 0 00000033",
            fetch_vld_c1, fetch_instr_c1);
        end
      end
    end
    idle();
  endtask

  task automatic test_starve();
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      fetch_req_c0  = 1'b1;
      fetch_addr_c0 = 32'h200;
      ld_req_c0     = (k < 5);
      ld_addr_c0    = 32'h100;
      #1;
      if (k < 4) begin
        checks++;
        if ({fetch_gnt_c0, ld_gnt_c0} !== 2'b10) begin
          errors++;
          $display("FAIL starve_deny[%0d]: got %b want 10",
            k, {fetch_gnt_c0, ld_gnt_c0});
        end
      end else if (k == 4) begin
        checks++;
        if ({fetch_gnt_c0, ld_gnt_c0} !== 2'b01 ||
            mem_addr_c0 !== 15'h40) begin
          errors++;
          $display("FAIL starve_force: got %b %h want 01 0040",
            {fetch_gnt_c0, ld_gnt_c0}, mem_addr_c0);
        end
      end else if (k == 5) begin
        checks++;
        if (ld_vld_c1 !== 1'b1 || ld_rdata_c1 !== 32'hCAFE0100 ||
            fetch_vld_c1 !== 1'b0 || fetch_gnt_c0 !== 1'b1) begin
          errors++;
          $display("FAIL starve_data: got %b %h %b %b want 1 cafe0100 0 1",
            ld_vld_c1, ld_rdata_c1, fetch_vld_c1, fetch_gnt_c0);
        end
      end else begin
        checks++;
        if (fetch_vld_c1 !== 1'b1 || ld_vld_c1 !== 1'b0) begin
          errors++;
          $display("FAIL starve_after: got %b %b want 1 0",
            fetch_vld_c1, ld_vld_c1);
        end
      end
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_lock();
    logic [31:0] wa [3] = '{32'h40, 32'h44, 32'h48};
    logic [31:0] wd [3] = '{32'hDEADBEEF, 32'h12345678, 32'h9ABCDEF0};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ld_req_c0     = 1'b1;
      ld_we_c0      = 1'b1;
      ld_lock_c0    = 1'b1;
      ld_addr_c0    = wa[i];
      ld_wdata_c0   = wd[i];
      fetch_req_c0  = (i > 0);
      fetch_addr_c0 = 32'h0;
      #1;
      checks++;
      if ({fetch_gnt_c0, ld_gnt_c0, mem_we_c0} !== 3'b011 ||
          mem_addr_c0 !== AW'(wa[i] >> 2) ||
          mem_wdata_c0 !== wd[i] || locked !== (i > 0) ||
          ld_vld_c1 !== 1'b0) begin
        errors++;
        $display("FAIL lock_wr[%0d]: got %b %h %h lk=%b v=%b",
          i, {fetch_gnt_c0, ld_gnt_c0, mem_we_c0}, mem_addr_c0,
          mem_wdata_c0, locked, ld_vld_c1);
      end
    end
    @(negedge clk);
    ld_req_c0  = 1'b0;
    ld_we_c0   = 1'b0;
    ld_lock_c0 = 1'b0;
    #1;
    checks++;
    if (locked !== 1'b1 || fetch_gnt_c0 !== 1'b0) begin
      errors++;
      $display("FAIL lock_drop: got lk=%b fg=%b want 1 0",
        locked, fetch_gnt_c0);
    end
    @(negedge clk);
    fetch_addr_c0 = 32'h40;
    #1;
    checks++;
    if (locked !== 1'b0 || fetch_gnt_c0 !== 1'b1 ||
        mem_addr_c0 !== 15'h10) begin
      errors++;
      $display("FAIL lock_release: got lk=%b fg=%b a=%h want 0 1 0010",
        locked, fetch_gnt_c0, mem_addr_c0);
    end
    @(negedge clk);
    fetch_req_c0 = 1'b0;
    #1;
    checks++;
    if (fetch_vld_c1 !== 1'b1 || fetch_instr_c1 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL lock_readback: got %b %h want 1 deadbeef",
        fetch_vld_c1, fetch_instr_c1);
    end
    idle();
  endtask

  task automatic test_out_of_range();
    @(negedge clk);
    ld_req_c0  = 1'b1;
    ld_addr_c0 = 32'h0002_0000;
    #1;
    checks++;
    if (ld_gnt_c0 !== 1'b1 || mem_en_c0 !== 1'b0) begin
      errors++;
      $display("FAIL oor_gnt: got g=%b en=%b want 1 0",
        ld_gnt_c0, mem_en_c0);
    end
    @(negedge clk);
    idle();
    fetch_req_c0  = 1'b1;
    fetch_addr_c0 = 32'h0002_0004;
    #1;
    checks++;
    if (ld_err_c1 !== 1'b1 || ld_vld_c1 !== 1'b0 ||
        ld_rdata_c1 !== 32'hCAFE0100) begin
      errors++;
      $display("FAIL oor_err: got e=%b v=%b d=%h want 1 0 cafe0100",
        ld_err_c1, ld_vld_c1, ld_rdata_c1);
    end
    checks++;
    if (mem_en_c0 !== 1'b1 || mem_addr_c0 !== 15'h1) begin
      errors++;
      $display("FAIL fetch_wrap: got en=%b a=%h want 1 0001",
        mem_en_c0, mem_addr_c0);
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (ld_err_c1 !== 1'b0 || fetch_instr_c1 !== 32'h22) begin
      errors++;
      $display("FAIL wrap_data: got e=%b i=%h want 0 00000022",
        ld_err_c1, fetch_instr_c1);
    end
  endtask

  task automatic test_ld_back_to_back();
    logic [31:0] exp [4] = '{32'h0, 32'h11, 32'h22, 32'h22};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ld_req_c0  = (i < 2);
      ld_addr_c0 = (i == 1) ? 32'h4 : 32'h0;
      #1;
      if (i > 0) begin
        checks++;
        if (ld_vld_c1 !== (i < 3) || ld_rdata_c1 !== exp[i]) begin
          errors++;
          $display("FAIL ld_b2b[%0d]: got %b %h want %b %h",
            i, ld_vld_c1, ld_rdata_c1, (i < 3), exp[i]);
        end
      end
    end
    idle();
  endtask

`ifdef PMEM_ARB_STATS_EN
  task automatic test_stats();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (conflict_cnt !== 16'd0) begin
      errors++;
      $display("FAIL stats_reset: got %0d want 0", conflict_cnt);
    end
    repeat (10) begin
      @(negedge clk);
      fetch_req_c0 = 1'b1;
      ld_req_c0    = 1'b1;
      ld_addr_c0   = 32'h8;
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (conflict_cnt !== 16'd10) begin
      errors++;
      $display("FAIL stats_count: got %0d want 10", conflict_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fetch_b2b();
    test_starve();
    test_lock();
    test_out_of_range();
    test_ld_back_to_back();
`ifdef PMEM_ARB_STATS_EN
    test_stats();
`endif
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
